i2c_txn_arbiter: RTL and testbench
==================================

Name: i2c_txn_arbiter

Overview:
Shares the single byte-level I2C master engine between NUM_REQ on-chip requesters (EEPROM reader, LED/config writer, debug port, and others).
- Latches one requester's transaction descriptor: device address, register address, rw, length, write byte.
- Issues the descriptor to the engine and steers returned read bytes back to the owner.
- Reports completion or NACK per requester.
- Grants round-robin, one transaction at a time; the engine owns all SDA/SCL timing.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
MAX_LEN, 8, maximum bytes per read transaction; requested lengths above this are clamped
TIMEOUT_CYC, 4096, clk_4MHz cycles allowed in WAIT before abort (used only with I2C_TIMEOUT_EN)

Ports:
clk_4MHz  in  1  system clock; single clock domain
rst_n  in  1  asynchronous active-low reset
req  in  NUM_REQ  per-requester transaction request; held high until that requester's done pulse
req_dev_addr  in  NUM_REQ*7  packed 7-bit device addresses; requester i uses bits [7i+6:7i]
req_reg_addr  in  NUM_REQ*8  packed register addresses
req_rw  in  NUM_REQ  0 = write, 1 = read
req_len  in  NUM_REQ*4  read byte count; 0 is treated as 1
req_wdata  in  NUM_REQ*8  write data byte
grant  out  NUM_REQ  one-hot owner indication; held from ISSUE through RESP
done  out  NUM_REQ  one-cycle completion pulse to the owner
nack  out  NUM_REQ  one-cycle pulse coincident with done when the engine reported NACK or the transaction timed out
rdata  out  8  read byte routed to the owner
rdata_valid  out  1  one-cycle strobe qualifying rdata
rdata_id  out  3  owner index for rdata
eng_cmd_valid  out  1  command valid to the engine
eng_cmd_ready  in  1  engine accepts the command
eng_dev_addr  out  7  latched device address
eng_reg_addr  out  8  latched register address
eng_rw  out  1  latched rw
eng_len  out  4  latched, clamped length
eng_wdata  out  8  latched write byte
eng_rdata  in  8  byte from the engine
eng_rdata_valid  in  1  strobe qualifying eng_rdata
eng_done  in  1  engine finished (STOP sent)
eng_nack  in  1  qualifies eng_done: slave NACKed
eng_abort  out  1  one-cycle abort request to the engine

Behaviour:
- Reset (asynchronous, rst_n = 0):
  - State = IDLE.
  - All outputs = 0.
  - Round-robin pointer = NUM_REQ-1, so req[0] has first priority.
  - Byte counter = 0.
- Asserting rst_n low mid-transaction drops grant and eng_cmd_valid immediately. No done pulse is issued.

States and transitions:
- IDLE: when any req bit is high, go to ARB.
- ARB (1 cycle):
  - Winner = first set req bit searching from pointer+1, wrapping modulo NUM_REQ.
  - Latch the winner's descriptor and owner index.
  - len = max(1, min(req_len, MAX_LEN)).
  - Go to ISSUE.
- ISSUE:
  - grant[owner] = 1 and eng_cmd_valid = 1; eng_* fields are stable.
  - In the cycle eng_cmd_valid && eng_cmd_ready, go to WAIT.
- WAIT:
  - Each eng_rdata_valid with byte counter < len: drive rdata = eng_rdata, rdata_valid = 1, rdata_id = owner on the next cycle (1-cycle latency), then increment the counter.
  - Bytes beyond len are discarded.
  - eng_rdata_valid during a write transaction is ignored.
  - On eng_done: capture eng_nack and go to RESP.
  - If eng_rdata_valid and eng_done arrive in the same cycle, the byte is still forwarded.
- RESP (1 cycle):
  - done[owner] = 1; nack[owner] = captured NACK or timeout.
  - pointer = owner; clear the byte counter.
  - grant drops on exit; go to IDLE.

Request-line rules:
- A requester dropping req after ARB does not cancel its transaction. It still receives done.
- req changes on other requesters have no effect until the next ARB.
- The minimum gap between consecutive grants is 2 cycles (RESP, IDLE→ARB).
- Fairness: with all req bits high continuously, grants rotate 0,1,2,3,0,...

Optional Feature:
I2C_TIMEOUT_EN
- Defined:
  - A 16-bit counter runs in WAIT and clears on entry to WAIT.
  - When it reaches TIMEOUT_CYC-1 without eng_done: pulse eng_abort for 1 cycle and go to RESP with nack forced to 1.
  - A later eng_done from that transaction is ignored while in IDLE.
- Undefined:
  - No counter is built; eng_abort is tied to 0.
  - WAIT exits only on eng_done.

Test Plan:
1. Single read: req[0] = 1, dev = 0x50, reg = 0x50, rw = 1, len = 3; engine returns 0xA1, 0xB2, 0xC3, then done → three rdata_valid strobes with rdata_id = 0 in order; done[0] = 1, nack[0] = 0; grant[0] high from ISSUE through RESP.
2. Round-robin: req = 4'b1111 held, each engine transaction lasting 10 cycles → grant order 0,1,2,3,0; done pulses follow the same order.
3. Write with NACK: req[2] = 1, rw = 0, wdata = 0xAC; engine returns eng_done with eng_nack = 1 → eng_rw = 0, eng_wdata = 0xAC; done[2] and nack[2] pulse together; no rdata_valid.
4. Length edges:
   - req_len = 0 → eng_len = 1.
   - req_len = 15 → eng_len = 8; engine sends 10 bytes → exactly 8 rdata_valid strobes.
5. Reset mid-WAIT: rst_n low during the 2nd byte of a len = 4 read → grant, rdata_valid, eng_cmd_valid = 0 immediately; after release, req[1] and req[0] both high → req[0] granted first.
6. I2C_TIMEOUT_EN defined, TIMEOUT_CYC = 64, engine never responds → eng_abort pulses exactly 64 cycles after WAIT entry; done and nack pulse for the owner; without the macro, the block stays in WAIT indefinitely.

Source files
------------

// File: rtl/i2c_txn_arbiter_if.sv
// ============================================================================
// Module      : i2c_txn_arbiter_if
// Description : Requester-side and engine-side signal bundle of the I2C
//               transaction arbiter. The slave modport is the arbiter's view;
//               the master modport is the view of the surrounding logic
//               (requesters plus byte engine).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface i2c_txn_arbiter_if #(
    parameter int NUM_REQ = 4
);
    // requester side
    logic [NUM_REQ-1:0]   req;
    logic [NUM_REQ*7-1:0] req_dev_addr;
    logic [NUM_REQ*8-1:0] req_reg_addr;
    logic [NUM_REQ-1:0]   req_rw;
    logic [NUM_REQ*4-1:0] req_len;
    logic [NUM_REQ*8-1:0] req_wdata;
    logic [NUM_REQ-1:0]   grant;
    logic [NUM_REQ-1:0]   done;
    logic [NUM_REQ-1:0]   nack;
    logic [7:0]           rdata;
    logic                 rdata_valid;
    logic [2:0]           rdata_id;

    // engine side
    logic                 eng_cmd_valid;
    logic                 eng_cmd_ready;
    logic [6:0]           eng_dev_addr;
    logic [7:0]           eng_reg_addr;
    logic                 eng_rw;
    logic [3:0]           eng_len;
    logic [7:0]           eng_wdata;
    logic [7:0]           eng_rdata;
    logic                 eng_rdata_valid;
    logic                 eng_done;
    logic                 eng_nack;
    logic                 eng_abort;

    modport slave (
        input  req, req_dev_addr, req_reg_addr, req_rw, req_len, req_wdata,
        output grant, done, nack, rdata, rdata_valid, rdata_id,
        output eng_cmd_valid, eng_dev_addr, eng_reg_addr, eng_rw, eng_len,
        output eng_wdata, eng_abort,
        input  eng_cmd_ready, eng_rdata, eng_rdata_valid, eng_done, eng_nack
    );

    modport master (
        output req, req_dev_addr, req_reg_addr, req_rw, req_len, req_wdata,
        input  grant, done, nack, rdata, rdata_valid, rdata_id,
        input  eng_cmd_valid, eng_dev_addr, eng_reg_addr, eng_rw, eng_len,
        input  eng_wdata, eng_abort,
        output eng_cmd_ready, eng_rdata, eng_rdata_valid, eng_done, eng_nack
    );
endinterface

`default_nettype wire

// File: rtl/i2c_txn_arbiter.sv
// ============================================================================
// Module      : i2c_txn_arbiter
// Description : Round-robin arbiter sharing one byte-level I2C master engine
//               among NUM_REQ requesters. Latches the winner's descriptor,
//               issues it to the engine, routes read bytes back to the owner
//               and pulses done/nack to it. One transaction at a time.
//               Optional macro I2C_TIMEOUT_EN adds a WAIT watchdog that
//               aborts the engine after TIMEOUT_CYC cycles.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module i2c_txn_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int MAX_LEN     = 8,
    parameter int TIMEOUT_CYC = 4096
) (
    input  wire logic        clk_4MHz,
    input  wire logic        rst_n,
    i2c_txn_arbiter_if.slave arb_bus
);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_ARB   = 3'd1;
    localparam logic [2:0] c_ST_ISSUE = 3'd2;
    localparam logic [2:0] c_ST_WAIT  = 3'd3;
    localparam logic [2:0] c_ST_RESP  = 3'd4;

    localparam logic [3:0]         c_MAX_LEN = 4'(MAX_LEN);
    localparam logic [2:0]         c_PTR_RST = 3'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] c_OH_LSB  = {{(NUM_REQ-1){1'b0}}, 1'b1};

    // Reject configurations the 3-bit owner index and 4-bit length cannot carry
    if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_LEN < 1 || MAX_LEN > 15 || TIMEOUT_CYC < 2)
    begin : g_bad_cfg
        $error("i2c_txn_arbiter: unsupported parameter set");
    end

    logic [2:0] r_state;
    logic [2:0] w_next_state;
    logic [2:0] r_ptr;
    logic [2:0] r_owner;
    logic [6:0] r_dev;
    logic [7:0] r_reg;
    logic       r_rw;
    logic [3:0] r_len;
    logic [7:0] r_wdata;
    logic [3:0] r_cnt;
    logic       r_nack;
    logic [7:0] r_rdata;
    logic       r_rdata_valid;
    logic [2:0] r_rdata_id;

    logic       w_found;
    logic [2:0] w_winner;
    int         w_idx;
    logic [6:0] w_sel_dev;
    logic [7:0] w_sel_reg;
    logic       w_sel_rw;
    logic [3:0] w_sel_len;
    logic [3:0] w_clamp_len;
    logic [7:0] w_sel_wdata;
    logic       w_take_byte;
    logic       w_timeout;

    logic [NUM_REQ-1:0] w_owner_oh;
    logic [NUM_REQ-1:0] w_grant;
    logic [NUM_REQ-1:0] w_done;
    logic [NUM_REQ-1:0] w_nack;
    logic               w_cmd_valid;

    // Round-robin search: first set req bit after the pointer, wrapping
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = int'(r_ptr) + k;
            if (w_idx >= NUM_REQ) begin
                w_idx = w_idx - NUM_REQ;
            end
            if (!w_found && arb_bus.req[w_idx]) begin
                w_found  = 1'b1;
                w_winner = 3'(w_idx);
            end
        end
    end

    // Pick the winner's descriptor out of the packed request buses
    always_comb begin
        w_sel_dev   = '0;
        w_sel_reg   = '0;
        w_sel_rw    = 1'b0;
        w_sel_len   = '0;
        w_sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_winner == 3'(i)) begin
                w_sel_dev   = arb_bus.req_dev_addr[i*7 +: 7];
                w_sel_reg   = arb_bus.req_reg_addr[i*8 +: 8];
                w_sel_rw    = arb_bus.req_rw[i];
                w_sel_len   = arb_bus.req_len[i*4 +: 4];
                w_sel_wdata = arb_bus.req_wdata[i*8 +: 8];
            end
        end
    end

    // Length 0 means one byte; anything above MAX_LEN is clamped
    always_comb begin
        if (w_sel_len == 4'd0) begin
            w_clamp_len = 4'd1;
        end else if (w_sel_len > c_MAX_LEN) begin
            w_clamp_len = c_MAX_LEN;
        end else begin
            w_clamp_len = w_sel_len;
        end
    end

    // Only read transactions forward bytes, and only up to the latched length
    assign w_take_byte = (r_state == c_ST_WAIT) && arb_bus.eng_rdata_valid &&
                         r_rw && (r_cnt < r_len);

`ifdef I2C_TIMEOUT_EN
    logic [15:0] r_tmo_cnt;
    logic        r_abort;

    // A done arriving on the deadline cycle wins over the abort
    assign w_timeout = (r_state == c_ST_WAIT) && !arb_bus.eng_done &&
                       (r_tmo_cnt == 16'(TIMEOUT_CYC - 1));

    // Watchdog counts WAIT cycles; held at zero outside WAIT so entry starts at 0
    always_ff @(posedge clk_4MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_tmo_cnt <= '0;
            r_abort   <= 1'b0;
        end else begin
            r_abort <= w_timeout;
            if (r_state == c_ST_WAIT) begin
                r_tmo_cnt <= r_tmo_cnt + 16'd1;
            end else begin
                r_tmo_cnt <= '0;
            end
        end
    end

    assign arb_bus.eng_abort = r_abort;
`else
    assign w_timeout         = 1'b0;
    assign arb_bus.eng_abort = 1'b0;
`endif

    // State register
    always_ff @(posedge clk_4MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE:  if (|arb_bus.req) w_next_state = c_ST_ARB;
            c_ST_ARB:   w_next_state = w_found ? c_ST_ISSUE : c_ST_IDLE;
            c_ST_ISSUE: if (arb_bus.eng_cmd_ready) w_next_state = c_ST_WAIT;
            c_ST_WAIT:  if (arb_bus.eng_done || w_timeout) w_next_state = c_ST_RESP;
            c_ST_RESP:  w_next_state = c_ST_IDLE;
            default:    w_next_state = c_ST_IDLE;
        endcase
    end

    // FSM outputs: grant spans ISSUE..RESP, done/nack only in RESP
    always_comb begin
        w_owner_oh  = c_OH_LSB << r_owner;
        w_grant     = '0;
        w_done      = '0;
        w_nack      = '0;
        w_cmd_valid = 1'b0;
        case (r_state)
            c_ST_ISSUE: begin
                w_grant     = w_owner_oh;
                w_cmd_valid = 1'b1;
            end
            c_ST_WAIT: begin
                w_grant = w_owner_oh;
            end
            c_ST_RESP: begin
                w_grant = w_owner_oh;
                w_done  = w_owner_oh;
                w_nack  = r_nack ? w_owner_oh : '0;
            end
            default: ;
        endcase
    end

    // Descriptor latch, read-byte steering, NACK capture and pointer update
    always_ff @(posedge clk_4MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr         <= c_PTR_RST;
            r_owner       <= '0;
            r_dev         <= '0;
            r_reg         <= '0;
            r_rw          <= 1'b0;
            r_len         <= '0;
            r_wdata       <= '0;
            r_cnt         <= '0;
            r_nack        <= 1'b0;
            r_rdata       <= '0;
            r_rdata_valid <= 1'b0;
            r_rdata_id    <= '0;
        end else begin
            r_rdata_valid <= 1'b0;
            case (r_state)
                c_ST_ARB: begin
                    if (w_found) begin
                        r_owner <= w_winner;
                        r_dev   <= w_sel_dev;
                        r_reg   <= w_sel_reg;
                        r_rw    <= w_sel_rw;
                        r_len   <= w_clamp_len;
                        r_wdata <= w_sel_wdata;
                        r_cnt   <= '0;
                        r_nack  <= 1'b0;
                    end
                end
                c_ST_WAIT: begin
                    if (w_take_byte) begin
                        r_rdata       <= arb_bus.eng_rdata;
                        r_rdata_valid <= 1'b1;
                        r_rdata_id    <= r_owner;
                        r_cnt         <= r_cnt + 4'd1;
                    end
                    if (arb_bus.eng_done) begin
                        r_nack <= arb_bus.eng_nack;
                    end else if (w_timeout) begin
                        r_nack <= 1'b1;
                    end
                end
                c_ST_RESP: begin
                    r_ptr <= r_owner;
                    r_cnt <= '0;
                end
                default: ;
            endcase
        end
    end

    assign arb_bus.grant         = w_grant;
    assign arb_bus.done          = w_done;
    assign arb_bus.nack          = w_nack;
    assign arb_bus.rdata         = r_rdata;
    assign arb_bus.rdata_valid   = r_rdata_valid;
    assign arb_bus.rdata_id      = r_rdata_id;
    assign arb_bus.eng_cmd_valid = w_cmd_valid;
    assign arb_bus.eng_dev_addr  = r_dev;
    assign arb_bus.eng_reg_addr  = r_reg;
    assign arb_bus.eng_rw        = r_rw;
    assign arb_bus.eng_len       = r_len;
    assign arb_bus.eng_wdata     = r_wdata;

endmodule

`default_nettype wire

// File: tb/tb_i2c_txn_arbiter.sv
// ============================================================================
// Module      : tb_i2c_txn_arbiter
// Description : Scoreboard bench for i2c_txn_arbiter. Stimulus pushes the
//               expected engine commands and owner responses; a monitor pops
//               and compares whenever the DUT presents them.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_i2c_txn_arbiter;

    localparam int NUM_REQ = 4;

    logic clk_4MHz = 1'b0;
    logic rst_n    = 1'b0;

    always #125 clk_4MHz = ~clk_4MHz;

    i2c_txn_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

    i2c_txn_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .MAX_LEN     (8),
        .TIMEOUT_CYC (64)
    ) dut (
        .clk_4MHz (clk_4MHz),
        .rst_n    (rst_n),
        .arb_bus  (bus)
    );

    typedef struct packed {
        logic       is_done;
        logic [7:0] data;
        logic [2:0] id;
        logic [3:0] dn;
        logic [3:0] nk;
    } rsp_t;

    rsp_t          rsp_q[$];
    logic [31:0]   cmd_q[$];
    int            n_vec  = 0;
    int            n_miss = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic bound_expired(input string name);
        n_vec++;
        n_miss++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    task automatic exp_cmd(input logic [3:0] g, input logic [6:0] dev, input logic [7:0] ra,
                           input logic rw, input logic [3:0] len, input logic [7:0] wd);
        cmd_q.push_back({g, dev, ra, rw, len, wd});
    endtask

    task automatic exp_rd(input logic [2:0] id, input logic [7:0] d);
        rsp_t e;
        e = '{is_done: 1'b0, data: d, id: id, dn: 4'h0, nk: 4'h0};
        rsp_q.push_back(e);
    endtask

    task automatic exp_done(input logic [3:0] dn, input logic [3:0] nk);
        rsp_t e;
        e = '{is_done: 1'b1, data: 8'h00, id: 3'd0, dn: dn, nk: nk};
        rsp_q.push_back(e);
    endtask

    task automatic set_desc(input int i, input logic [6:0] dev, input logic [7:0] ra,
                            input logic rw, input logic [3:0] len, input logic [7:0] wd);
        bus.req_dev_addr[i*7 +: 7] = dev;
        bus.req_reg_addr[i*8 +: 8] = ra;
        bus.req_rw[i]              = rw;
        bus.req_len[i*4 +: 4]      = len;
        bus.req_wdata[i*8 +: 8]    = wd;
    endtask

    // Monitor: commands at the handshake, read bytes, completion pulses
    initial begin
        rsp_t e;
        logic [31:0] c;
        forever begin
            @(negedge clk_4MHz);
            if (bus.eng_cmd_valid && bus.eng_cmd_ready) begin
                if (cmd_q.size() == 0) begin
                    check("cmd unexpected", 32'(bus.eng_cmd_valid), 32'h0);
                end else begin
                    c = cmd_q.pop_front();
                    check("cmd fields", {bus.grant, bus.eng_dev_addr, bus.eng_reg_addr,
                                         bus.eng_rw, bus.eng_len, bus.eng_wdata}, c);
                end
            end
            if (bus.rdata_valid) begin
                if (rsp_q.size() == 0) begin
                    check("rdata unexpected", 32'(bus.rdata_valid), 32'h0);
                end else begin
                    e = rsp_q.pop_front();
                    check("rdata", {21'b0, bus.rdata_id, bus.rdata},
                          e.is_done ? 32'hFFFF_FFFF : {21'b0, e.id, e.data});
                end
            end
            if (|bus.done) begin
                if (rsp_q.size() == 0) begin
                    check("done unexpected", 32'(bus.done), 32'h0);
                end else begin
                    e = rsp_q.pop_front();
                    check("grant/nack/done", {20'b0, bus.grant, bus.nack, bus.done},
                          e.is_done ? {20'b0, e.dn, e.nk, e.dn} : 32'hFFFF_FFFF);
                end
            end
        end
    end

    // Returns on the negedge of the ISSUE cycle
    task automatic wait_cmd();
        bit seen = 1'b0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk_4MHz);
            if (bus.eng_cmd_valid) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) bound_expired("eng_cmd_valid wait");
    endtask

    // Returns on the negedge of the RESP cycle
    task automatic wait_done();
        bit seen = 1'b0;
        for (int t = 0; t < 60; t++) begin
            if (|bus.done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk_4MHz);
        end
        if (!seen) bound_expired("done wait");
    endtask

    // Engine model: accept command, idle lat cycles, stream bytes, finish
    task automatic eng_serve(input int nbytes, input logic [7:0] base, input logic [7:0] step,
                             input logic nk, input int lat, input bit join_last);
        logic [7:0] b;
        wait_cmd();
        repeat (lat) @(negedge clk_4MHz);
        b = base;
        for (int k = 0; k < nbytes; k++) begin
            @(negedge clk_4MHz);
            bus.eng_rdata_valid = 1'b1;
            bus.eng_rdata       = b;
            b = b + step;
            if (join_last && k == nbytes - 1) begin
                bus.eng_done = 1'b1;
                bus.eng_nack = nk;
            end
        end
        @(negedge clk_4MHz);
        bus.eng_rdata_valid = 1'b0;
        if (!(join_last && nbytes > 0)) begin
            bus.eng_done = 1'b1;
            bus.eng_nack = nk;
            @(negedge clk_4MHz);
        end
        bus.eng_done = 1'b0;
        bus.eng_nack = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk_4MHz);
        bus.req = '0;
        rst_n   = 1'b0;
        repeat (2) @(negedge clk_4MHz);
        rst_n = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req             = '0;
        bus.req_dev_addr    = '0;
        bus.req_reg_addr    = '0;
        bus.req_rw          = '0;
        bus.req_len         = '0;
        bus.req_wdata       = '0;
        bus.eng_cmd_ready   = 1'b1;
        bus.eng_rdata       = '0;
        bus.eng_rdata_valid = 1'b0;
        bus.eng_done        = 1'b0;
        bus.eng_nack        = 1'b0;
        rst_n               = 1'b0;
        bus.req             = 4'b0001;   // requests must not leak through reset

        repeat (3) @(negedge clk_4MHz);
        check("reset grant",         32'(bus.grant),         32'h0);
        check("reset done",          32'(bus.done),          32'h0);
        check("reset nack",          32'(bus.nack),          32'h0);
        check("reset rdata_valid",   32'(bus.rdata_valid),   32'h0);
        check("reset eng_cmd_valid", 32'(bus.eng_cmd_valid), 32'h0);
        check("reset eng_abort",     32'(bus.eng_abort),     32'h0);
        bus.req = '0;
        rst_n   = 1'b1;

        // single read, last byte coincides with engine done
        set_desc(0, 7'h50, 8'h50, 1'b1, 4'd3, 8'h11);
        exp_cmd(4'b0001, 7'h50, 8'h50, 1'b1, 4'd3, 8'h11);
        exp_rd(3'd0, 8'hA1);
        exp_rd(3'd0, 8'hB2);
        exp_rd(3'd0, 8'hC3);
        exp_done(4'b0001, 4'b0000);
        bus.req[0] = 1'b1;
        eng_serve(3, 8'hA1, 8'h11, 1'b0, 0, 1'b1);
        wait_done();
        bus.req = '0;

        // round-robin from reset with all requests held
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) begin
            set_desc(i, 7'h10 + 7'(i), 8'h20 + 8'(i), 1'b0, 4'(i + 1), 8'h30 + 8'(i));
        end
        for (int g = 0; g < 5; g++) begin
            int o;
            o = g % NUM_REQ;
            exp_cmd(4'b0001 << o, 7'h10 + 7'(o), 8'h20 + 8'(o), 1'b0, 4'(o + 1), 8'h30 + 8'(o));
            exp_done(4'b0001 << o, 4'b0000);
        end
        bus.req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            eng_serve(0, 8'h00, 8'h00, 1'b0, 9, 1'b0);
            wait_done();
        end
        bus.req = '0;

        // write with NACK; stray byte from the engine must be ignored; len 0 -> 1
        set_desc(2, 7'h2A, 8'h07, 1'b0, 4'd0, 8'hAC);
        exp_cmd(4'b0100, 7'h2A, 8'h07, 1'b0, 4'd1, 8'hAC);
        exp_done(4'b0100, 4'b0100);
        bus.req[2] = 1'b1;
        eng_serve(1, 8'h55, 8'h00, 1'b1, 2, 1'b0);
        wait_done();
        bus.req = '0;

        // length 15 clamps to 8; engine over-delivers 10 bytes
        set_desc(3, 7'h51, 8'h00, 1'b1, 4'd15, 8'h00);
        exp_cmd(4'b1000, 7'h51, 8'h00, 1'b1, 4'd8, 8'h00);
        for (int k = 0; k < 8; k++) exp_rd(3'd3, 8'(k + 1));
        exp_done(4'b1000, 4'b0000);
        bus.req[3] = 1'b1;
        eng_serve(10, 8'h01, 8'h01, 1'b0, 1, 1'b0);
        wait_done();
        bus.req = '0;

        // reset during the second byte of a 4-byte read
        set_desc(1, 7'h22, 8'h33, 1'b1, 4'd4, 8'h00);
        exp_cmd(4'b0010, 7'h22, 8'h33, 1'b1, 4'd4, 8'h00);
        exp_rd(3'd1, 8'h5A);
        bus.req[1] = 1'b1;
        wait_cmd();
        @(negedge clk_4MHz);
        bus.eng_rdata_valid = 1'b1;
        bus.eng_rdata       = 8'h5A;
        @(negedge clk_4MHz);
        bus.eng_rdata = 8'h5B;
        #2 rst_n = 1'b0;
        #1;
        check("mid-reset grant",         32'(bus.grant),         32'h0);
        check("mid-reset rdata_valid",   32'(bus.rdata_valid),   32'h0);
        check("mid-reset eng_cmd_valid", 32'(bus.eng_cmd_valid), 32'h0);
        check("mid-reset done",          32'(bus.done),          32'h0);
        bus.eng_rdata_valid = 1'b0;
        set_desc(0, 7'h40, 8'h41, 1'b0, 4'd2, 8'h42);
        bus.req = 4'b0011;
        repeat (2) @(negedge clk_4MHz);
        rst_n = 1'b1;
        exp_cmd(4'b0001, 7'h40, 8'h41, 1'b0, 4'd2, 8'h42);
        exp_done(4'b0001, 4'b0000);
        exp_cmd(4'b0010, 7'h22, 8'h33, 1'b1, 4'd4, 8'h00);
        exp_done(4'b0010, 4'b0000);
        eng_serve(0, 8'h00, 8'h00, 1'b0, 3, 1'b0);
        wait_done();
        eng_serve(0, 8'h00, 8'h00, 1'b0, 3, 1'b0);
        wait_done();
        bus.req = '0;

        // unresponsive engine
        set_desc(0, 7'h60, 8'h61, 1'b1, 4'd2, 8'h00);
        exp_cmd(4'b0001, 7'h60, 8'h61, 1'b1, 4'd2, 8'h00);
`ifdef I2C_TIMEOUT_EN
        begin
            int n;
            n = -1;
            exp_done(4'b0001, 4'b0001);
            bus.req[0] = 1'b1;
            wait_cmd();
            for (int t = 0; t < 200; t++) begin
                @(negedge clk_4MHz);
                if (bus.eng_abort) begin
                    n = t;
                    break;
                end
            end
            check("abort latency", 32'(n), 32'd64);
            wait_done();
            bus.req = '0;
            @(negedge clk_4MHz);
            check("abort one cycle", 32'(bus.eng_abort), 32'h0);
            bus.eng_done = 1'b1;
            @(negedge clk_4MHz);
            bus.eng_done = 1'b0;
            repeat (4) @(negedge clk_4MHz);
        end
`else
        exp_done(4'b0001, 4'b0000);
        bus.req[0] = 1'b1;
        wait_cmd();
        repeat (200) @(negedge clk_4MHz);
        check("grant held in WAIT", 32'(bus.grant),     32'h1);
        check("eng_abort tied low", 32'(bus.eng_abort), 32'h0);
        bus.eng_done = 1'b1;
        @(negedge clk_4MHz);
        bus.eng_done = 1'b0;
        wait_done();
        bus.req = '0;
`endif

        repeat (5) @(negedge clk_4MHz);
        check("response queue drained", 32'(rsp_q.size()), 32'h0);
        check("command queue drained",  32'(cmd_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

`default_nettype wire
